// File: rtl/key_entry_collector.sv
// rtl/key_entry_collector.sv - debounced keypad entry collector with valid/ready hand-off
module key_entry_collector #(
  parameter int CODE_W     = 4,
  parameter int MAX_DIGITS = 8,
  parameter int DEBOUNCE   = 4,
  parameter int LEN_W      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [CODE_W-1:0]            in_code,
  input  logic                         entry_ready,
  output logic                         entry_valid,
  output logic [MAX_DIGITS*CODE_W-1:0] entry_data,
  output logic [LEN_W-1:0]             entry_len,
  output logic                         entry_overflow,
  output logic                         key_strobe
);

  localparam int DATA_W = MAX_DIGITS * CODE_W;
  localparam int CNT_W  = $clog2(DEBOUNCE + 1);

  localparam logic [CODE_W-1:0] KEY_LAST_DIGIT = CODE_W'(9);
  localparam logic [CODE_W-1:0] KEY_CLEAR      = CODE_W'(10);
  localparam logic [CODE_W-1:0] KEY_ENTER      = CODE_W'(11);
  localparam logic [CODE_W-1:0] KEY_BACK       = CODE_W'(12);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_DIGITS);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [CNT_W-1:0]    cnt_inc;
  logic [CODE_W-1:0]   cap_code, cap_nxt;
  logic                valid_d;
  logic                accept;

  assign cnt_inc = cnt + CNT_ONE;

  // Delay the encoder's combinational valid so it lines up with its registered code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_d <= 1'b0;
    else        valid_d <= in_valid;
  end

  // Debounce FSM state, sample counter and captured key code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      cap_code <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      cap_code <= cap_nxt;
    end
  end

  // Next-state logic; accept fires on the edge where the press count reaches DEBOUNCE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cap_nxt   = cap_code;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (valid_d) begin
          cap_nxt   = in_code;
          cnt_nxt   = CNT_ONE;
          state_nxt = PRESS;
        end
      end
      PRESS: begin
        if (valid_d && (in_code == cap_code)) begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == CNT_DONE) begin
            accept    = 1'b1;
            state_nxt = HELD;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      HELD: begin
        if (!valid_d) begin
          cnt_nxt   = CNT_ONE;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (!valid_d) begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == CNT_DONE) state_nxt = IDLE;
        end else begin
          state_nxt = HELD;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Entry buffer: the handshake has priority, a pending entry freezes the buffer,
  // otherwise an accepted key applies its action.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_strobe     <= 1'b0;
      entry_valid    <= 1'b0;
      entry_data     <= '0;
      entry_len      <= '0;
      entry_overflow <= 1'b0;
    end else begin
      key_strobe <= accept;
      if (entry_valid) begin
        if (entry_ready) begin
          entry_valid    <= 1'b0;
          entry_data     <= '0;
          entry_len      <= '0;
          entry_overflow <= 1'b0;
        end
      end else if (accept) begin
        if (cap_code <= KEY_LAST_DIGIT) begin
          if (entry_len < LEN_MAX) begin
            entry_data <= {entry_data[DATA_W-CODE_W-1:0], cap_code};
            entry_len  <= entry_len + LEN_ONE;
          end else begin
            entry_overflow <= 1'b1;
          end
        end else if (cap_code == KEY_CLEAR) begin
          entry_data     <= '0;
          entry_len      <= '0;
          entry_overflow <= 1'b0;
        end else if (cap_code == KEY_ENTER) begin
          if (entry_len != '0) entry_valid <= 1'b1;
        end else if (cap_code == KEY_BACK) begin
          if (entry_len != '0) begin
            entry_data <= entry_data >> CODE_W;
            entry_len  <= entry_len - LEN_ONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_key_entry_collector.sv
// tb/tb_key_entry_collector.sv - self-checking bench for key_entry_collector
module tb_key_entry_collector;

  localparam int D = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  in_code;
  logic        entry_ready;
  logic        entry_valid;
  logic [31:0] entry_data;
  logic [3:0]  entry_len;
  logic        entry_overflow;
  logic        key_strobe;

  key_entry_collector #(.CODE_W(4), .MAX_DIGITS(8), .DEBOUNCE(D), .LEN_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_code(in_code),
    .entry_ready(entry_ready), .entry_valid(entry_valid), .entry_data(entry_data),
    .entry_len(entry_len), .entry_overflow(entry_overflow), .key_strobe(key_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: key history in terms of runs of identical samples, plus the entry buffer.
  bit [31:0] m_data;
  int        m_len;
  bit        m_ovf, m_valid, m_strobe;
  int        run, inv;
  bit        held;
  logic [3:0] run_code;
  bit        pv, rel_pending;
  logic [3:0] cur_k;
  int        dut_strobes, mdl_strobes;

  task automatic model_reset();
    m_data = 0; m_len = 0; m_ovf = 0; m_valid = 0; m_strobe = 0;
    run = 0; inv = 0; held = 0; run_code = 0; pv = 0;
  endtask

  task automatic model_step(input bit sv, input logic [3:0] sk, input bit rdy);
    bit acc;
    acc = 0;
    if (held) begin
      if (!sv) begin
        inv++;
        if (inv >= D) begin held = 0; run = 0; end
      end else inv = 0;
    end else if (!sv) begin
      run = 0;
    end else if (run == 0 || sk == run_code) begin
      run_code = sk;
      run++;
      if (run == D) begin acc = 1; held = 1; inv = 0; end
    end else begin
      run = 0;
    end
    m_strobe = acc;
    if (m_valid) begin
      if (rdy) begin m_valid = 0; m_data = 0; m_len = 0; m_ovf = 0; end
    end else if (acc) begin
      if (run_code <= 9) begin
        if (m_len < 8) begin m_data = (m_data << 4) | 32'(run_code); m_len++; end
        else m_ovf = 1;
      end else if (run_code == 4'hA) begin
        m_data = 0; m_len = 0; m_ovf = 0;
      end else if (run_code == 4'hB) begin
        if (m_len > 0) m_valid = 1;
      end else if (run_code == 4'hC) begin
        if (m_len > 0) begin m_data = m_data >> 4; m_len--; end
      end
    end
  endtask

  // One clock cycle: the bench plays the encoder (combinational valid, registered code).
  task automatic cyc(input bit v, input logic [3:0] k, input bit rdy);
    bit sv;
    logic [3:0] sk;
    @(negedge clk);
    if (rel_pending) begin rst_n = 1'b1; rel_pending = 0; end
    sv = pv;
    sk = cur_k;
    in_code = cur_k;
    in_valid = v;
    entry_ready = rdy;
    pv = v;
    cur_k = k;
    @(posedge clk);
    #1;
    model_step(sv, sk, rdy);
    dut_strobes += int'(key_strobe);
    mdl_strobes += int'(m_strobe);
  endtask

  task automatic press(input logic [3:0] k, input int n);
    repeat (n) cyc(1'b1, k, 1'b0);
  endtask

  task automatic gap(input int n);
    repeat (n) cyc(1'b0, 4'h0, 1'b0);
  endtask

  task automatic type_key(input logic [3:0] k);
    press(k, D + 2);
    gap(D + 2);
  endtask

  task automatic reset_low();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
  endtask

  task automatic reset_release();
    repeat (2) @(posedge clk);
    rel_pending = 1;
  endtask

  task automatic test_reset();
    n_cmp++; if (key_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_strobe got %0b want 0", key_strobe); end
    n_cmp++; if (entry_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", entry_valid); end
    n_cmp++; if (entry_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", entry_data); end
    n_cmp++; if (entry_len !== 4'd0) begin n_fail++; $display("FAIL reset_len got %0d want 0", entry_len); end
    n_cmp++; if (entry_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %0b want 0", entry_overflow); end
    reset_release();
  endtask

  task automatic test_single_press();
    int s0;
    s0 = dut_strobes;
    press(4'h5, 6);
    gap(6);
    n_cmp++; if (dut_strobes - s0 !== 1) begin n_fail++; $display("FAIL t1_strobes got %0d want 1", dut_strobes - s0); end
    n_cmp++; if (entry_data[3:0] !== 4'h5) begin n_fail++; $display("FAIL t1_digit got %h want 5", entry_data[3:0]); end
    n_cmp++; if (entry_len !== 4'd1) begin n_fail++; $display("FAIL t1_len got %0d want 1", entry_len); end
  endtask

  task automatic test_glitch();
    int s0;
    type_key(4'hA);
    s0 = dut_strobes;
    press(4'h3, 2);
    press(4'h7, 5);
    gap(6);
    n_cmp++; if (dut_strobes - s0 !== 1) begin n_fail++; $display("FAIL t2_strobes got %0d want 1", dut_strobes - s0); end
    n_cmp++; if (entry_data[3:0] !== 4'h7) begin n_fail++; $display("FAIL t2_digit got %h want 7", entry_data[3:0]); end
    n_cmp++; if (entry_len !== 4'd1) begin n_fail++; $display("FAIL t2_len got %0d want 1", entry_len); end
  endtask

  task automatic test_enter_hold();
    int s0;
    type_key(4'hA);
    type_key(4'h1); type_key(4'h2); type_key(4'h3); type_key(4'h4);
    type_key(4'hB);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 4'h0, 1'b0);
      n_cmp++; if (entry_valid !== 1'b1) begin n_fail++; $display("FAIL t3_valid_held cycle %0d got %0b want 1", i, entry_valid); end
    end
    s0 = dut_strobes;
    type_key(4'h9);
    type_key(4'hA);
    n_cmp++; if (dut_strobes - s0 !== 2) begin n_fail++; $display("FAIL t3_frozen_strobes got %0d want 2", dut_strobes - s0); end
    n_cmp++; if (entry_data[15:0] !== 16'h1234) begin n_fail++; $display("FAIL t3_data got %h want 1234", entry_data[15:0]); end
    n_cmp++; if (entry_len !== 4'd4) begin n_fail++; $display("FAIL t3_len got %0d want 4", entry_len); end
    cyc(1'b0, 4'h0, 1'b1);
    n_cmp++; if (entry_valid !== 1'b0) begin n_fail++; $display("FAIL t3_valid_after got %0b want 0", entry_valid); end
    n_cmp++; if (entry_len !== 4'd0) begin n_fail++; $display("FAIL t3_len_after got %0d want 0", entry_len); end
    n_cmp++; if (entry_data !== 32'h0) begin n_fail++; $display("FAIL t3_data_after got %h want 0", entry_data); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 9; i++) type_key(4'(i));
    n_cmp++; if (entry_len !== 4'd8) begin n_fail++; $display("FAIL t4_len got %0d want 8", entry_len); end
    n_cmp++; if (entry_data !== 32'h12345678) begin n_fail++; $display("FAIL t4_data got %h want 12345678", entry_data); end
    n_cmp++; if (entry_overflow !== 1'b1) begin n_fail++; $display("FAIL t4_ovf got %0b want 1", entry_overflow); end
    type_key(4'hA);
    n_cmp++; if (entry_len !== 4'd0) begin n_fail++; $display("FAIL t4_clear_len got %0d want 0", entry_len); end
    n_cmp++; if (entry_overflow !== 1'b0) begin n_fail++; $display("FAIL t4_clear_ovf got %0b want 0", entry_overflow); end
  endtask

  task automatic test_backspace();
    type_key(4'h4); type_key(4'h2); type_key(4'hC);
    n_cmp++; if (entry_data[3:0] !== 4'h4) begin n_fail++; $display("FAIL t5_digit got %h want 4", entry_data[3:0]); end
    n_cmp++; if (entry_len !== 4'd1) begin n_fail++; $display("FAIL t5_len1 got %0d want 1", entry_len); end
    type_key(4'hC);
    n_cmp++; if (entry_len !== 4'd0) begin n_fail++; $display("FAIL t5_len0 got %0d want 0", entry_len); end
    type_key(4'hC);
    n_cmp++; if (entry_len !== 4'd0) begin n_fail++; $display("FAIL t5_underflow got %0d want 0", entry_len); end
    n_cmp++; if (entry_data !== 32'h0) begin n_fail++; $display("FAIL t5_data got %h want 0", entry_data); end
    type_key(4'hB);
    n_cmp++; if (entry_valid !== 1'b0) begin n_fail++; $display("FAIL t5_enter_empty got %0b want 0", entry_valid); end
  endtask

  task automatic test_reset_mid();
    int first;
    type_key(4'h1); type_key(4'hB);
    n_cmp++; if (entry_valid !== 1'b1) begin n_fail++; $display("FAIL t6_valid_before got %0b want 1", entry_valid); end
    reset_low();
    n_cmp++; if (entry_valid !== 1'b0) begin n_fail++; $display("FAIL t6_rst_valid got %0b want 0", entry_valid); end
    n_cmp++; if (entry_len !== 4'd0) begin n_fail++; $display("FAIL t6_rst_len got %0d want 0", entry_len); end
    n_cmp++; if (entry_data !== 32'h0) begin n_fail++; $display("FAIL t6_rst_data got %h want 0", entry_data); end
    reset_release();
    press(4'h6, 2);
    reset_low();
    n_cmp++; if (key_strobe !== 1'b0 || entry_overflow !== 1'b0) begin n_fail++; $display("FAIL t6_rst_press got strobe=%0b ovf=%0b want 0 0", key_strobe, entry_overflow); end
    reset_release();
    first = 0;
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 4'h6, 1'b0);
      if (key_strobe === 1'b1 && first == 0) first = i;
    end
    n_cmp++; if (first !== D + 1) begin n_fail++; $display("FAIL t6_redebounce got cycle %0d want %0d", first, D + 1); end
    gap(D + 2);
    n_cmp++; if (entry_data[3:0] !== 4'h6 || entry_len !== 4'd1) begin n_fail++; $display("FAIL t6_digit got %h/%0d want 6/1", entry_data[3:0], entry_len); end
  endtask

  task automatic test_random();
    int cycles, n;
    bit rdy;
    logic [3:0] k;
    cycles = 0;
    while (cycles < 2000) begin
      k = ($urandom_range(0, 9) < 6) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
      n = $urandom_range(1, D + 4);
      for (int p = 0; p < 2; p++) begin
        for (int i = 0; i < n; i++) begin
          rdy = ($urandom_range(0, 3) == 0);
          cyc(p == 0, k, rdy);
          cycles++;
          n_cmp++;
          if (key_strobe !== m_strobe || entry_valid !== m_valid || entry_data !== m_data ||
              entry_len !== 4'(m_len) || entry_overflow !== m_ovf) begin
            n_fail++;
            if (n_fail < 20)
              $display("FAIL rand cycle %0d got s=%0b v=%0b d=%h l=%0d o=%0b want s=%0b v=%0b d=%h l=%0d o=%0b",
                       cycles, key_strobe, entry_valid, entry_data, entry_len, entry_overflow,
                       m_strobe, m_valid, m_data, m_len, m_ovf);
          end
        end
        n = $urandom_range(1, D + 3);
      end
    end
    n_cmp++; if (dut_strobes !== mdl_strobes) begin n_fail++; $display("FAIL rand_strobe_total got %0d want %0d", dut_strobes, mdl_strobes); end
  endtask

  initial begin
    rst_n = 1'b1;
    in_valid = 1'b0;
    in_code = 4'h0;
    entry_ready = 1'b0;
    cur_k = 4'h0;
    rel_pending = 0;
    dut_strobes = 0;
    mdl_strobes = 0;
    model_reset();
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single_press();
    test_glitch();
    test_enter_hold();
    test_overflow();
    test_backspace();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
